// File: rtl/pipe_share_arb.sv
// Round-robin scheduler sharing one fixed-latency delay-line datapath among NREQ requesters.
// A tag pipeline follows each issued word so that its result returns to the requester that owns it.
module pipe_share_arb #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 8,
  parameter int LATENCY = 4,
  parameter int CNTW    = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_data,
  input  logic                  pause,
  input  logic                  flush,
  output logic [NREQ-1:0]       gnt,
  output logic [WIDTH-1:0]      pipe_in,
  output logic                  pipe_in_valid,
  input  logic [WIDTH-1:0]      pipe_out,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]      rsp_data,
  output logic [CNTW-1:0]       inflight,
  output logic                  busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]                ptr_q, ptr_d;
  logic [WIDTH-1:0]             pipe_in_q, pipe_in_d;
  logic                         pipe_in_valid_q, pipe_in_valid_d;
  logic [LATENCY:0]             tag_v_q, tag_v_d;
  logic [LATENCY:0][NREQ-1:0]   tag_id_q, tag_id_d;
  logic [CNTW-1:0]              inflight_q, inflight_d;

  logic [NREQ-1:0]              gnt_s;
  logic [PW-1:0]                gnt_idx_s;
  logic                         gnt_any_s;
  logic                         rsp_fire_s;

  // Round-robin search starting just above the last granted index.
  always_comb begin
    int idx;
    gnt_s     = '0;
    gnt_idx_s = ptr_q;
    gnt_any_s = 1'b0;
    idx       = 0;
    if (!rst && !flush && !pause) begin
      for (int i = 1; i <= NREQ; i++) begin
        idx = (int'(ptr_q) + i) % NREQ;
        if (!gnt_any_s && req[idx]) begin
          gnt_any_s      = 1'b1;
          gnt_s[idx]     = 1'b1;
          gnt_idx_s      = idx[PW-1:0];
        end else begin
          gnt_any_s      = gnt_any_s;
        end
      end
    end else begin
      gnt_any_s = 1'b0;
    end
  end

  // A tag reaching the last stage lines up with its word on pipe_out; flush or reset suppress it.
  assign rsp_fire_s = tag_v_q[LATENCY] & ~flush & ~rst;

  // Next-state logic for pointer, issue register, tag pipeline and in-flight count.
  always_comb begin
    ptr_d           = ptr_q;
    pipe_in_d       = '0;
    pipe_in_valid_d = 1'b0;
    if (gnt_any_s) begin
      ptr_d           = gnt_idx_s;
      pipe_in_d       = req_data[int'(gnt_idx_s)*WIDTH +: WIDTH];
      pipe_in_valid_d = 1'b1;
    end else begin
      ptr_d = ptr_q;
    end

    if (flush) begin
      tag_v_d  = '0;
      tag_id_d = '0;
    end else begin
      tag_v_d  = {tag_v_q[LATENCY-1:0], gnt_any_s};
      tag_id_d = {tag_id_q[LATENCY-1:0], gnt_s};
    end

    if (flush) begin
      inflight_d = '0;
    end else begin
      case ({gnt_any_s, rsp_fire_s})
        2'b10:   inflight_d = inflight_q + CNTW'(1);
        2'b01:   inflight_d = inflight_q - CNTW'(1);
        default: inflight_d = inflight_q;
      endcase
    end
  end

  // State registers with synchronous reset; pointer resets so requester 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q           <= PW'(NREQ - 1);
      pipe_in_q       <= '0;
      pipe_in_valid_q <= 1'b0;
      tag_v_q         <= '0;
      tag_id_q        <= '0;
      inflight_q      <= '0;
    end else begin
      ptr_q           <= ptr_d;
      pipe_in_q       <= pipe_in_d;
      pipe_in_valid_q <= pipe_in_valid_d;
      tag_v_q         <= tag_v_d;
      tag_id_q        <= tag_id_d;
      inflight_q      <= inflight_d;
    end
  end

  // Output mapping.
  always_comb begin
    if (rsp_fire_s) begin
      rsp_valid = tag_id_q[LATENCY];
    end else begin
      rsp_valid = '0;
    end
  end

  assign gnt           = gnt_s;
  assign pipe_in       = pipe_in_q;
  assign pipe_in_valid = pipe_in_valid_q;
  assign rsp_data      = pipe_out;
  assign inflight      = inflight_q;
  assign busy          = (inflight_q != '0);

endmodule

// File: tb/tb_pipe_share_arb.sv
// Directed bench for pipe_share_arb: table of per-cycle vectors plus hand-written corner sequences.
// A LATENCY-deep delay line stands in for the shared datapath.
module tb_pipe_share_arb;

  localparam int NREQ = 4, WIDTH = 8, LATENCY = 4, CNTW = 3;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*WIDTH-1:0] req_data = '0;
  logic                  pause = 1'b0;
  logic                  flush = 1'b0;
  logic [NREQ-1:0]       gnt;
  logic [WIDTH-1:0]      pipe_in;
  logic                  pipe_in_valid;
  logic [WIDTH-1:0]      pipe_out;
  logic [NREQ-1:0]       rsp_valid;
  logic [WIDTH-1:0]      rsp_data;
  logic [CNTW-1:0]       inflight;
  logic                  busy;

  logic [WIDTH-1:0] dl [0:LATENCY-1];
  int pass_cnt = 0;
  int total_cnt = 0;

  pipe_share_arb #(.NREQ(NREQ), .WIDTH(WIDTH), .LATENCY(LATENCY), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .pause(pause), .flush(flush),
    .gnt(gnt), .pipe_in(pipe_in), .pipe_in_valid(pipe_in_valid), .pipe_out(pipe_out),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .inflight(inflight), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    dl[0] <= pipe_in;
    for (int k = 1; k < LATENCY; k++) dl[k] <= dl[k-1];
  end
  assign pipe_out = dl[LATENCY-1];

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    logic        pause;
    logic        flush;
    logic        rst;
    logic [3:0]  gnt;
    logic        piv;
    logic [7:0]  pin;
    logic [3:0]  rsp;
    logic [7:0]  rspd;
    logic [2:0]  infl;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [3:0] r, input logic [31:0] d, input logic p, input logic f,
                              input logic rs, input logic [3:0] g, input logic pv, input logic [7:0] pi,
                              input logic [3:0] rv, input logic [7:0] rd, input logic [2:0] inf);
    vec_t v;
    v.req = r; v.data = d; v.pause = p; v.flush = f; v.rst = rs;
    v.gnt = g; v.piv = pv; v.pin = pi; v.rsp = rv; v.rspd = rd; v.infl = inf;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Drive one cycle's inputs just after the edge, then settle to mid-cycle for sampling.
  task automatic next_cycle(input logic [3:0] r, input logic [31:0] d, input logic p, input logic f,
                            input logic rs);
    @(posedge clk);
    #1;
    req = r; req_data = d; pause = p; flush = f; rst = rs;
    #4;
  endtask

  initial begin
    // reset
    tbl.push_back(mk(4'h0, 32'h0, 1'b0, 1'b0, 1'b1, 4'h0, 1'b0, 8'h00, 4'h0, 8'h00, 3'd0));
    tbl.push_back(mk(4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 8'h00, 4'h0, 8'h00, 3'd0));
    // single request round trip
    tbl.push_back(mk(4'h1, 32'h0000_00A5, 1'b0, 1'b0, 1'b0, 4'h1, 1'b0, 8'h00, 4'h0, 8'h00, 3'd0));
    tbl.push_back(mk(4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 8'hA5, 4'h0, 8'h00, 3'd1));
    tbl.push_back(mk(4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 8'h00, 4'h0, 8'h00, 3'd1));
    tbl.push_back(mk(4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 8'h00, 4'h0, 8'h00, 3'd1));
    tbl.push_back(mk(4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 8'h00, 4'h0, 8'h00, 3'd1));
    tbl.push_back(mk(4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 8'h00, 4'h1, 8'hA5, 3'd1));
    tbl.push_back(mk(4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 8'h00, 4'h0, 8'h00, 3'd0));
    // reset restores pointer so streaming starts at requester 0
    tbl.push_back(mk(4'h0, 32'h0, 1'b0, 1'b0, 1'b1, 4'h0, 1'b0, 8'h00, 4'h0, 8'h00, 3'd0));
    // continuous streaming from all four requesters
    tbl.push_back(mk(4'hF, 32'h1312_1110, 1'b0, 1'b0, 1'b0, 4'h1, 1'b0, 8'h00, 4'h0, 8'h00, 3'd0));
    tbl.push_back(mk(4'hF, 32'h1312_1110, 1'b0, 1'b0, 1'b0, 4'h2, 1'b1, 8'h10, 4'h0, 8'h00, 3'd1));
    tbl.push_back(mk(4'hF, 32'h1312_1110, 1'b0, 1'b0, 1'b0, 4'h4, 1'b1, 8'h11, 4'h0, 8'h00, 3'd2));
    tbl.push_back(mk(4'hF, 32'h1312_1110, 1'b0, 1'b0, 1'b0, 4'h8, 1'b1, 8'h12, 4'h0, 8'h00, 3'd3));
    tbl.push_back(mk(4'hF, 32'h1312_1110, 1'b0, 1'b0, 1'b0, 4'h1, 1'b1, 8'h13, 4'h0, 8'h00, 3'd4));
    tbl.push_back(mk(4'hF, 32'h1312_1110, 1'b0, 1'b0, 1'b0, 4'h2, 1'b1, 8'h10, 4'h1, 8'h10, 3'd5));
    tbl.push_back(mk(4'hF, 32'h1312_1110, 1'b0, 1'b0, 1'b0, 4'h4, 1'b1, 8'h11, 4'h2, 8'h11, 3'd5));
    tbl.push_back(mk(4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 8'h12, 4'h4, 8'h12, 3'd5));
    tbl.push_back(mk(4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 8'h00, 4'h8, 8'h13, 3'd4));
    tbl.push_back(mk(4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 8'h00, 4'h1, 8'h10, 3'd3));
    tbl.push_back(mk(4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 8'h00, 4'h2, 8'h11, 3'd2));
    tbl.push_back(mk(4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 8'h00, 4'h4, 8'h12, 3'd1));
    tbl.push_back(mk(4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 8'h00, 4'h0, 8'h00, 3'd0));

    foreach (tbl[i]) begin
      next_cycle(tbl[i].req, tbl[i].data, tbl[i].pause, tbl[i].flush, tbl[i].rst);
      chk($sformatf("v%0d gnt", i), 32'(gnt), 32'(tbl[i].gnt));
      chk($sformatf("v%0d pipe_in_valid", i), 32'(pipe_in_valid), 32'(tbl[i].piv));
      chk($sformatf("v%0d pipe_in", i), 32'(pipe_in), 32'(tbl[i].pin));
      chk($sformatf("v%0d rsp_valid", i), 32'(rsp_valid), 32'(tbl[i].rsp));
      if (tbl[i].rsp != 4'h0) chk($sformatf("v%0d rsp_data", i), 32'(rsp_data), 32'(tbl[i].rspd));
      chk($sformatf("v%0d inflight", i), 32'(inflight), 32'(tbl[i].infl));
      chk($sformatf("v%0d busy", i), 32'(busy), 32'(tbl[i].infl != 3'd0));
    end

    // Wrap-around: last grant was requester 2, so 0 precedes 1.
    next_cycle(4'h3, 32'h0000_2120, 1'b0, 1'b0, 1'b0);
    chk("wrap gnt0", 32'(gnt), 32'h1);
    next_cycle(4'h3, 32'h0000_2120, 1'b0, 1'b0, 1'b0);
    chk("wrap gnt1", 32'(gnt), 32'h2);
    next_cycle(4'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("wrap pipe_in", 32'(pipe_in), 32'h21);
    for (int i = 0; i < 6; i++) begin
      next_cycle(4'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      if (i == 2) begin
        chk("wrap rsp0", 32'(rsp_valid), 32'h1);
        chk("wrap rsp0 data", 32'(rsp_data), 32'h20);
      end else if (i == 3) begin
        chk("wrap rsp1", 32'(rsp_valid), 32'h2);
        chk("wrap rsp1 data", 32'(rsp_data), 32'h21);
      end else begin
        chk("wrap idle rsp", 32'(rsp_valid), 32'h0);
      end
    end
    chk("wrap drained", 32'(inflight), 32'h0);

    // Flush discards three in-flight words.
    next_cycle(4'hF, 32'h4342_4140, 1'b0, 1'b0, 1'b0);
    chk("fl gnt0", 32'(gnt), 32'h4);
    next_cycle(4'hF, 32'h4342_4140, 1'b0, 1'b0, 1'b0);
    chk("fl gnt1", 32'(gnt), 32'h8);
    next_cycle(4'hF, 32'h4342_4140, 1'b0, 1'b0, 1'b0);
    chk("fl gnt2", 32'(gnt), 32'h1);
    next_cycle(4'h1, 32'h4342_4140, 1'b0, 1'b1, 1'b0);
    chk("fl cycle gnt", 32'(gnt), 32'h0);
    chk("fl cycle inflight", 32'(inflight), 32'h3);
    chk("fl cycle rsp", 32'(rsp_valid), 32'h0);
    for (int i = 0; i < 7; i++) begin
      next_cycle(4'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      if (i == 0) chk("fl piv", 32'(pipe_in_valid), 32'h0);
      chk($sformatf("fl rsp %0d", i), 32'(rsp_valid), 32'h0);
      chk($sformatf("fl inflight %0d", i), 32'(inflight), 32'h0);
    end

    // Pause holds off the grant; the released grant returns LATENCY+1 cycles later.
    for (int i = 0; i < 3; i++) begin
      next_cycle(4'h4, 32'h005C_0000, 1'b1, 1'b0, 1'b0);
      chk($sformatf("pause gnt %0d", i), 32'(gnt), 32'h0);
    end
    next_cycle(4'h4, 32'h005C_0000, 1'b0, 1'b0, 1'b0);
    chk("pause release gnt", 32'(gnt), 32'h4);
    for (int k = 1; k <= 5; k++) begin
      next_cycle(4'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      if (k == 1) chk("pause pipe_in", 32'(pipe_in), 32'h5C);
      if (k < 5) begin
        chk($sformatf("pause early rsp %0d", k), 32'(rsp_valid), 32'h0);
      end else begin
        chk("pause rsp", 32'(rsp_valid), 32'h4);
        chk("pause rsp data", 32'(rsp_data), 32'h5C);
      end
    end

    // Reset mid-operation drops in-flight words and restores the pointer.
    next_cycle(4'hF, 32'h3322_1100, 1'b0, 1'b0, 1'b0);
    chk("mrst gnt0", 32'(gnt), 32'h8);
    next_cycle(4'hF, 32'h3322_1100, 1'b0, 1'b0, 1'b0);
    chk("mrst gnt1", 32'(gnt), 32'h1);
    next_cycle(4'hF, 32'h3322_1100, 1'b0, 1'b0, 1'b1);
    chk("mrst rst gnt", 32'(gnt), 32'h0);
    for (int i = 0; i < 8; i++) begin
      next_cycle(4'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      if (i == 0) begin
        chk("mrst piv", 32'(pipe_in_valid), 32'h0);
        chk("mrst pipe_in", 32'(pipe_in), 32'h0);
      end
      chk($sformatf("mrst rsp %0d", i), 32'(rsp_valid), 32'h0);
      chk($sformatf("mrst inflight %0d", i), 32'(inflight), 32'h0);
      chk($sformatf("mrst busy %0d", i), 32'(busy), 32'h0);
    end
    next_cycle(4'hF, 32'h3322_1100, 1'b0, 1'b0, 1'b0);
    chk("mrst first gnt", 32'(gnt), 32'h1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
